// File: rtl/dram_arb_pkg.sv
// Shared types and sizing helpers for the multi-port DRAM front-end arbiter.
package dram_arb_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } arb_state_t;

    // A single-port build still needs a one-bit tag to keep vector widths legal.
    function automatic int tag_width(input int num_ports);
        return (num_ports > 1) ? $clog2(num_ports) : 1;
    endfunction

    localparam int DEFAULT_NUM_PORTS = 2;
    localparam int DEFAULT_TAG_WIDTH = tag_width(DEFAULT_NUM_PORTS);

endpackage

// File: rtl/dram_tag_fifo.sv
// In-order FIFO of requester tags for reads that the DRAM has accepted but not yet returned.
module dram_tag_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 1,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_tag,
    input  logic             pop,
    output logic [WIDTH-1:0] head_tag,
    output logic [CNT_W-1:0] count,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count == '0);
    assign full     = (count == CNT_W'(DEPTH));
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign head_tag = mem[rd_ptr];

    // Depth is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= push_tag;
    end

endmodule

// File: rtl/dram_port_arbiter.sv
// Round-robin front-end that funnels N requester channels into one DRAM command port
// and steers in-order read beats back to the issuing channel.
module dram_port_arbiter
    import dram_arb_pkg::*;
#(
    parameter int NUM_PORTS          = 2,
    parameter int ADDR_WIDTH         = 27,
    parameter int DATA_WIDTH         = 128,
    parameter int MASK_WIDTH         = 16,
    parameter int MAX_RD_OUTSTANDING = 4
) (
    input  logic                             clock,
    input  logic                             resetn,
    input  logic [NUM_PORTS-1:0]             port_ren,
    input  logic [NUM_PORTS-1:0]             port_wen,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  port_addr,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]  port_wdata,
    input  logic [NUM_PORTS*MASK_WIDTH-1:0]  port_wmask,
    output logic [NUM_PORTS-1:0]             port_ready,
    output logic [DATA_WIDTH-1:0]            port_rdata,
    output logic [NUM_PORTS-1:0]             port_rvalid,
    input  logic                             dram_init_calib_complete,
    input  logic                             dram_busy,
    output logic                             dram_ren,
    output logic                             dram_wen,
    output logic [ADDR_WIDTH-1:0]            dram_addr,
    output logic [DATA_WIDTH-1:0]            dram_wdata,
    output logic [MASK_WIDTH-1:0]            dram_wmask,
    input  logic [DATA_WIDTH-1:0]            dram_rdata,
    input  logic                             dram_rdata_valid,
    output logic                             rd_err
);

    localparam int TAG_W = tag_width(NUM_PORTS);
    localparam int CNT_W = $clog2(MAX_RD_OUTSTANDING) + 1;

    arb_state_t           state;
    arb_state_t           state_next;
    logic [TAG_W-1:0]     last_grant;
    logic [TAG_W-1:0]     cmd_port;
    logic [TAG_W-1:0]     winner;
    logic [TAG_W-1:0]     head_tag;
    logic [CNT_W-1:0]     tag_count;
    logic [CNT_W:0]       reads_in_flight;
    logic                 tag_empty;
    logic                 read_ok;
    logic                 accept;
    logic                 any_eligible;
    logic                 grant;
    logic [NUM_PORTS-1:0] eligible;

    function automatic logic [TAG_W-1:0] rr_pick(input logic [NUM_PORTS-1:0] req,
                                                 input logic [TAG_W-1:0]     last);
        logic [TAG_W-1:0] pick;
        logic             found;
        int               idx;
        pick  = '0;
        found = 1'b0;
        for (int off = 1; off <= NUM_PORTS; off++) begin
            idx = (int'(last) + off) % NUM_PORTS;
            if (!found && req[idx]) begin
                pick  = TAG_W'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    // A read sitting in the command register counts against the tag budget.
    assign reads_in_flight = {1'b0, tag_count} + (CNT_W + 1)'(dram_ren);
    assign read_ok         = reads_in_flight < (CNT_W + 1)'(MAX_RD_OUTSTANDING);
    assign eligible        = port_wen | (port_ren & {NUM_PORTS{read_ok}});
    assign any_eligible    = |eligible;
    assign winner          = rr_pick(eligible, last_grant);
    assign accept          = (state == ISSUE) && !dram_busy;

    // Gating on resetn keeps port_ready quiet while the block is held in reset.
    assign grant = resetn && dram_init_calib_complete && any_eligible &&
                   ((state == IDLE) || accept);

    always_comb begin
        state_next = state;
        if (grant) begin
            state_next = ISSUE;
        end else if (accept) begin
            state_next = IDLE;
        end
    end

    always_comb begin
        port_ready = '0;
        if (grant) port_ready[winner] = 1'b1;
    end

    always_comb begin
        port_rvalid = '0;
        if (dram_rdata_valid && !tag_empty) port_rvalid[head_tag] = 1'b1;
    end

    assign port_rdata = dram_rdata;

    // Command register: reloads on every grant, including back-to-back in ISSUE.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            last_grant <= TAG_W'(NUM_PORTS - 1);
            cmd_port   <= '0;
            dram_ren   <= 1'b0;
            dram_wen   <= 1'b0;
            dram_addr  <= '0;
            dram_wdata <= '0;
            dram_wmask <= '0;
            rd_err     <= 1'b0;
        end else begin
            state <= state_next;
            if (grant) begin
                dram_wen   <= port_wen[winner];
                dram_ren   <= ~port_wen[winner];
                dram_addr  <= port_addr[winner*ADDR_WIDTH +: ADDR_WIDTH];
                dram_wdata <= port_wdata[winner*DATA_WIDTH +: DATA_WIDTH];
                dram_wmask <= port_wmask[winner*MASK_WIDTH +: MASK_WIDTH];
                cmd_port   <= winner;
                last_grant <= winner;
            end else if (accept) begin
                dram_ren <= 1'b0;
                dram_wen <= 1'b0;
            end
            if (dram_rdata_valid && tag_empty) rd_err <= 1'b1;
        end
    end

    dram_tag_fifo #(
        .DEPTH (MAX_RD_OUTSTANDING),
        .WIDTH (TAG_W)
    ) u_tag_fifo (
        .clock    (clock),
        .resetn   (resetn),
        .push     (accept && dram_ren),
        .push_tag (cmd_port),
        .pop      (dram_rdata_valid),
        .head_tag (head_tag),
        .count    (tag_count),
        .empty    (tag_empty)
    );

endmodule

// File: tb/tb_dram_port_arbiter.sv
// Scenario bench for dram_port_arbiter: expected read destinations are queued at grant
// time and popped as beats come back.
module tb_dram_port_arbiter;

    localparam int NP = 2;
    localparam int AW = 27;
    localparam int DW = 128;
    localparam int MW = 16;

    logic             clock = 1'b0;
    logic             resetn;
    logic [NP-1:0]    port_ren, port_wen;
    logic [NP*AW-1:0] port_addr;
    logic [NP*DW-1:0] port_wdata;
    logic [NP*MW-1:0] port_wmask;
    logic [NP-1:0]    port_ready, port_rvalid;
    logic [DW-1:0]    port_rdata;
    logic             dram_init_calib_complete, dram_busy;
    logic             dram_ren, dram_wen;
    logic [AW-1:0]    dram_addr;
    logic [DW-1:0]    dram_wdata;
    logic [MW-1:0]    dram_wmask;
    logic [DW-1:0]    dram_rdata;
    logic             dram_rdata_valid;
    logic             rd_err;

    int n_cmp = 0;
    int n_fail = 0;
    int exp_q[$];
    int model_last = NP - 1;

    dram_port_arbiter #(
        .NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MASK_WIDTH(MW), .MAX_RD_OUTSTANDING(4)
    ) dut (
        .clock(clock), .resetn(resetn),
        .port_ren(port_ren), .port_wen(port_wen), .port_addr(port_addr),
        .port_wdata(port_wdata), .port_wmask(port_wmask),
        .port_ready(port_ready), .port_rdata(port_rdata), .port_rvalid(port_rvalid),
        .dram_init_calib_complete(dram_init_calib_complete), .dram_busy(dram_busy),
        .dram_ren(dram_ren), .dram_wen(dram_wen), .dram_addr(dram_addr),
        .dram_wdata(dram_wdata), .dram_wmask(dram_wmask),
        .dram_rdata(dram_rdata), .dram_rdata_valid(dram_rdata_valid), .rd_err(rd_err)
    );

    always #5 clock = ~clock;

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_port(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d,
                              input logic [MW-1:0] m);
        port_addr[p*AW +: AW]  = a;
        port_wdata[p*DW +: DW] = d;
        port_wmask[p*MW +: MW] = m;
    endtask

    function automatic int model_pick(input logic [1:0] elig, input int last);
        for (int off = 1; off <= NP; off++) begin
            int idx = (last + off) % NP;
            if (elig[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic test_reset();
        resetn = 1'b0;
        port_ren = '0; port_wen = '0; port_addr = '0; port_wdata = '0; port_wmask = '0;
        dram_init_calib_complete = 1'b0; dram_busy = 1'b0;
        dram_rdata = '0; dram_rdata_valid = 1'b0;
        #3;
        n_cmp++;
        if ({port_ready, port_rvalid, dram_ren, dram_wen, rd_err} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got ready=%b rvalid=%b ren=%b wen=%b err=%b required all 0",
                     port_ready, port_rvalid, dram_ren, dram_wen, rd_err);
        end
        n_cmp++;
        if (dram_addr !== '0 || dram_wdata !== '0 || dram_wmask !== '0) begin
            n_fail++;
            $display("FAIL reset_cmd: got addr=%h wdata=%h wmask=%h required 0",
                     dram_addr, dram_wdata, dram_wmask);
        end
        next_cycle();
        resetn = 1'b1;
        next_cycle();
    endtask

    task automatic test_calib_gate();
        dram_init_calib_complete = 1'b0;
        port_ren = 2'b01;
        drive_port(0, 27'h100, '0, '0);
        repeat (3) begin
            @(negedge clock);
            n_cmp++;
            if (port_ready !== 2'b00 || dram_ren !== 1'b0) begin
                n_fail++;
                $display("FAIL calib_low: got ready=%b ren=%b required 00/0", port_ready, dram_ren);
            end
            next_cycle();
        end
        dram_init_calib_complete = 1'b1;
        @(negedge clock);
        n_cmp++;
        if (port_ready !== 2'b01) begin
            n_fail++;
            $display("FAIL calib_grant: got ready=%b required 01", port_ready);
        end
        exp_q.push_back(0);
        model_last = 0;
        next_cycle();
        port_ren = 2'b00;
        @(negedge clock);
        n_cmp++;
        if (dram_ren !== 1'b1 || dram_addr !== 27'h100) begin
            n_fail++;
            $display("FAIL calib_cmd: got ren=%b addr=%h required 1/100", dram_ren, dram_addr);
        end
        next_cycle();
        dram_rdata = 128'hA0A0_0000_0000_0000_0000_0000_0000_00A0;
        dram_rdata_valid = 1'b1;
        @(negedge clock);
        begin
            int p = exp_q.pop_front();
            n_cmp++;
            if (port_rvalid !== (2'b01 << p) || port_rdata !== dram_rdata) begin
                n_fail++;
                $display("FAIL calib_beat: got rvalid=%b data=%h required %b", port_rvalid,
                         port_rdata, 2'b01 << p);
            end
        end
        next_cycle();
        dram_rdata_valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] beats [4];
        int            prev;
        beats[0] = {4{32'hAAAA_0001}};
        beats[1] = {4{32'hBBBB_0002}};
        beats[2] = {4{32'hCCCC_0003}};
        beats[3] = {4{32'hDDDD_0004}};
        prev = -1;
        port_ren = 2'b11;
        drive_port(0, 27'h200, '0, '0);
        drive_port(1, 27'h300, '0, '0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            if (i < 4) begin
                int w = (model_last + 1) % NP;
                n_cmp++;
                if (port_ready !== (2'b01 << w)) begin
                    n_fail++;
                    $display("FAIL b2b_grant%0d: got ready=%b required %b", i, port_ready, 2'b01 << w);
                end
                exp_q.push_back(w);
                model_last = w;
            end else begin
                n_cmp++;
                if (port_ready !== 2'b00) begin
                    n_fail++;
                    $display("FAIL b2b_stall: got ready=%b required 00", port_ready);
                end
            end
            if (prev >= 0) begin
                n_cmp++;
                if (dram_ren !== 1'b1 || dram_addr !== ((prev == 0) ? 27'h200 : 27'h300)) begin
                    n_fail++;
                    $display("FAIL b2b_cmd%0d: got ren=%b addr=%h required 1/%h", i, dram_ren,
                             dram_addr, (prev == 0) ? 27'h200 : 27'h300);
                end
            end
            if (i < 4) prev = model_last;
            next_cycle();
        end
        port_ren = 2'b00;
        for (int i = 0; i < 4; i++) begin
            dram_rdata = beats[i];
            dram_rdata_valid = 1'b1;
            @(negedge clock);
            begin
                int p = exp_q.pop_front();
                n_cmp++;
                if (port_rvalid !== (2'b01 << p) || port_rdata !== beats[i]) begin
                    n_fail++;
                    $display("FAIL b2b_beat%0d: got rvalid=%b data=%h required %b/%h", i,
                             port_rvalid, port_rdata, 2'b01 << p, beats[i]);
                end
            end
            next_cycle();
        end
        dram_rdata_valid = 1'b0;
    endtask

    task automatic test_fifo_full();
        int   m_count = 0;
        bit   m_issue = 0;
        bit   m_held_read = 0;
        port_ren = 2'b01;
        port_wen = 2'b10;
        drive_port(0, 27'h400, '0, '0);
        drive_port(1, 27'h500, {4{32'h5A5A_1234}}, 16'hFFFF);
        for (int c = 0; c < 12; c++) begin
            @(negedge clock);
            begin
                int         rif = m_count + ((m_issue && m_held_read) ? 1 : 0);
                logic [1:0] elig = {1'b1, (rif < 4)};
                int         w = model_pick(elig, model_last);
                n_cmp++;
                if (port_ready !== (2'b01 << w)) begin
                    n_fail++;
                    $display("FAIL full_grant%0d: got ready=%b required %b", c, port_ready, 2'b01 << w);
                end
                if (m_issue && m_held_read) begin
                    m_count++;
                    exp_q.push_back(0);
                end
                m_issue = 1;
                m_held_read = (w == 0);
                model_last = w;
            end
            next_cycle();
        end
        port_ren = 2'b00;
        port_wen = 2'b00;
        if (m_issue && m_held_read) exp_q.push_back(0);
        @(negedge clock);
        n_cmp++;
        if (port_ready !== 2'b00) begin
            n_fail++;
            $display("FAIL full_idle: got ready=%b required 00", port_ready);
        end
        next_cycle();
        dram_rdata = {4{32'h0BEE_F001}};
        dram_rdata_valid = 1'b1;
        @(negedge clock);
        begin
            int p = exp_q.pop_front();
            n_cmp++;
            if (port_rvalid !== (2'b01 << p)) begin
                n_fail++;
                $display("FAIL full_beat: got rvalid=%b required %b", port_rvalid, 2'b01 << p);
            end
        end
        next_cycle();
        dram_rdata_valid = 1'b0;
        port_ren = 2'b01;
        @(negedge clock);
        n_cmp++;
        if (port_ready !== 2'b01) begin
            n_fail++;
            $display("FAIL full_refill: got ready=%b required 01", port_ready);
        end
        exp_q.push_back(0);
        model_last = 0;
        next_cycle();
        port_ren = 2'b00;
        next_cycle();
        for (int i = 0; i < 4; i++) begin
            dram_rdata = DW'(i + 16'h7700);
            dram_rdata_valid = 1'b1;
            @(negedge clock);
            begin
                int p = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
                n_cmp++;
                if (p < 0 || port_rvalid !== (2'b01 << p)) begin
                    n_fail++;
                    $display("FAIL full_drain%0d: got rvalid=%b required port %0d", i, port_rvalid, p);
                end
            end
            next_cycle();
        end
        dram_rdata_valid = 1'b0;
    endtask

    task automatic test_busy_hold();
        logic [DW-1:0] wd;
        wd = {32'hDEAD_BEEF, 32'h0123_4567, 32'h89AB_CDEF, 32'hFEED_FACE};
        dram_busy = 1'b1;
        port_wen = 2'b10;
        drive_port(1, 27'h55, wd, 16'h00FF);
        @(negedge clock);
        n_cmp++;
        if (port_ready !== 2'b10) begin
            n_fail++;
            $display("FAIL busy_grant: got ready=%b required 10", port_ready);
        end
        model_last = 1;
        next_cycle();
        port_wen = 2'b00;
        drive_port(1, 27'h77, '1, 16'hFF00);
        repeat (5) begin
            @(negedge clock);
            n_cmp++;
            if (dram_wen !== 1'b1 || dram_ren !== 1'b0 || dram_addr !== 27'h55 ||
                dram_wdata !== wd || dram_wmask !== 16'h00FF) begin
                n_fail++;
                $display("FAIL busy_hold: got wen=%b ren=%b addr=%h wdata=%h wmask=%h required 1/0/55/%h/00ff",
                         dram_wen, dram_ren, dram_addr, dram_wdata, dram_wmask, wd);
            end
            next_cycle();
        end
        dram_busy = 1'b0;
        @(negedge clock);
        n_cmp++;
        if (dram_wen !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_release: got wen=%b required 1", dram_wen);
        end
        next_cycle();
        @(negedge clock);
        n_cmp++;
        if (dram_wen !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_accepted: got wen=%b required 0", dram_wen);
        end
        next_cycle();
    endtask

    task automatic test_rd_err();
        dram_rdata = {4{32'hBAD0_BAD0}};
        dram_rdata_valid = 1'b1;
        @(negedge clock);
        n_cmp++;
        if (port_rvalid !== 2'b00) begin
            n_fail++;
            $display("FAIL err_rvalid: got rvalid=%b required 00", port_rvalid);
        end
        next_cycle();
        dram_rdata_valid = 1'b0;
        repeat (3) begin
            @(negedge clock);
            n_cmp++;
            if (rd_err !== 1'b1) begin
                n_fail++;
                $display("FAIL err_sticky: got rd_err=%b required 1", rd_err);
            end
            next_cycle();
        end
    endtask

    task automatic test_async_reset();
        port_ren = 2'b01;
        drive_port(0, 27'h600, '0, '0);
        repeat (3) begin
            @(negedge clock);
            n_cmp++;
            if (port_ready !== 2'b01) begin
                n_fail++;
                $display("FAIL rst_fill: got ready=%b required 01", port_ready);
            end
            next_cycle();
        end
        port_ren = 2'b00;
        dram_busy = 1'b1;
        @(negedge clock);
        n_cmp++;
        if (dram_ren !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_held: got ren=%b required 1", dram_ren);
        end
        #2;
        resetn = 1'b0;
        #1;
        n_cmp++;
        if ({port_ready, port_rvalid, dram_ren, dram_wen, rd_err} !== 7'b0 ||
            dram_addr !== '0 || dram_wdata !== '0 || dram_wmask !== '0) begin
            n_fail++;
            $display("FAIL rst_async: got ren=%b wen=%b err=%b addr=%h required all 0",
                     dram_ren, dram_wen, rd_err, dram_addr);
        end
        exp_q.delete();
        model_last = NP - 1;
        next_cycle();
        resetn = 1'b1;
        dram_busy = 1'b0;
        port_ren = 2'b11;
        drive_port(0, 27'h700, '0, '0);
        drive_port(1, 27'h800, '0, '0);
        @(negedge clock);
        n_cmp++;
        if (port_ready !== 2'b01) begin
            n_fail++;
            $display("FAIL rst_first_grant: got ready=%b required 01", port_ready);
        end
        exp_q.push_back(0);
        model_last = 0;
        next_cycle();
        port_ren = 2'b00;
        @(negedge clock);
        n_cmp++;
        if (dram_ren !== 1'b1 || dram_addr !== 27'h700) begin
            n_fail++;
            $display("FAIL rst_cmd: got ren=%b addr=%h required 1/700", dram_ren, dram_addr);
        end
        next_cycle();
        dram_rdata = {4{32'h600D_600D}};
        dram_rdata_valid = 1'b1;
        @(negedge clock);
        begin
            int p = exp_q.pop_front();
            n_cmp++;
            if (port_rvalid !== (2'b01 << p) || rd_err !== 1'b0) begin
                n_fail++;
                $display("FAIL rst_beat: got rvalid=%b err=%b required %b/0", port_rvalid, rd_err,
                         2'b01 << p);
            end
        end
        next_cycle();
        dram_rdata_valid = 1'b0;
        @(negedge clock);
        n_cmp++;
        if (rd_err !== 1'b0 || port_rvalid !== 2'b00) begin
            n_fail++;
            $display("FAIL rst_after: got err=%b rvalid=%b required 0/00", rd_err, port_rvalid);
        end
        next_cycle();
    endtask

    initial begin
        test_reset();
        test_calib_gate();
        test_back_to_back();
        test_fifo_full();
        test_busy_hold();
        test_rd_err();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion required finish before 500000");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/dram_port_arbiter.md
# dram_port_arbiter

Multi-port front-end for the DRAM user interface. Sits between N requesters (instruction cache, data cache, DMA/SD-card engines) and the single-command DRAM wrapper port. It arbitrates round-robin, registers the chosen command, and holds it until the DRAM accepts it. It tracks outstanding reads in an in-order tag FIFO so each returning 128-bit read beat is steered to the port that issued it. This generalises the current single-requester DRAM hookup to NUM_PORTS channels with bounded read pipelining.

## Interface
- NUM_PORTS, 2: number of requester channels (1..8).
- ADDR_WIDTH, 27: DRAM user address width.
- DATA_WIDTH, 128: DRAM beat width.
- MASK_WIDTH, 16: byte-mask width (DATA_WIDTH/8).
- MAX_RD_OUTSTANDING, 4: tag FIFO depth, power of two, ≥2.

Ports:
- clock  in  1  single clock; the DRAM user clock.
- resetn  in  1  asynchronous, active-low reset.
- port_ren  in  NUM_PORTS  per-port read request, held until port_ready.
- port_wen  in  NUM_PORTS  per-port write request, held until port_ready. Both ren and wen set is illegal.
- port_addr  in  NUM_PORTS*ADDR_WIDTH  flattened per-port address; port i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- port_wdata  in  NUM_PORTS*DATA_WIDTH  flattened write data.
- port_wmask  in  NUM_PORTS*MASK_WIDTH  flattened byte mask, passed through unchanged.
- port_ready  out  NUM_PORTS  one-cycle pulse: request captured.
- port_rdata  out  DATA_WIDTH  read data, broadcast to all ports.
- port_rvalid  out  NUM_PORTS  one-hot, qualifies port_rdata.
- dram_init_calib_complete  in  1  no commands are issued while low.
- dram_busy  in  1  DRAM cannot take a command this cycle.
- dram_ren, dram_wen  out  1  registered command strobes.
- dram_addr  out  ADDR_WIDTH  registered address.
- dram_wdata  out  DATA_WIDTH  registered write data.
- dram_wmask  out  MASK_WIDTH  registered write mask.
- dram_rdata  in  DATA_WIDTH  read beat.
- dram_rdata_valid  in  1  read beat valid; beats return in issue order.
- rd_err  out  1  sticky: a beat arrived with the tag FIFO empty.

## Operation
- Eligible port: has ren or wen set. A read is also eligible only if reads_in_flight < MAX_RD_OUTSTANDING. reads_in_flight = tag FIFO count + (1 if a read sits in the command register).
- Grant: round-robin over eligible ports, starting at last_grant+1 and wrapping at NUM_PORTS. last_grant resets to NUM_PORTS-1, so port 0 wins first.
- State IDLE: if calib complete and any port is eligible:
  - load the winner's addr/wdata/wmask into the command register;
  - set dram_ren or dram_wen;
  - pulse port_ready[winner];
  - update last_grant;
  - go to ISSUE.
- State ISSUE: command held stable.
  - On a cycle with dram_busy=0 the command is accepted. A read pushes the winner's index into the tag FIFO.
  - If another port is eligible and calib is high in that same cycle, reload the register directly and stay in ISSUE (back-to-back, one command per cycle peak). Otherwise clear the strobes and go to IDLE.
- Read return: dram_rdata_valid with a non-empty FIFO → port_rdata = dram_rdata and port_rvalid = onehot(FIFO head), same cycle (combinational); then pop.
- Read return with an empty FIFO → beat dropped, rd_err set. rd_err is cleared only by reset.
- Push and pop in the same cycle → count unchanged.
- Full FIFO: reads stall, writes still proceed.
- Calib drops while a command is held → the held command stays held; no new grants.

## Timing
- Reset values: port_ready=0, port_rvalid=0, dram_ren=0, dram_wen=0, dram_addr=0, dram_wdata=0, dram_wmask=0, rd_err=0, state=IDLE, FIFO empty.
- Request to command: request seen at edge k → port_ready pulses in cycle k → dram_ren/wen high from cycle k+1.
- port_ready and the command-register load share the same edge. The requester may change its payload on the following cycle.
- Read data to port: 0 cycles from dram_rdata_valid.
- An asynchronous reset mid-operation discards the held command and all tags. The DRAM wrapper is reset in the same domain.

## Structure
- Package dram_arb_pkg: state enum (IDLE, ISSUE) and a tag width constant, $clog2(NUM_PORTS) with a minimum of 1.
- Sub-module dram_tag_fifo: synchronous FIFO, MAX_RD_OUTSTANDING deep, tag-wide, with count output. Pointers wrap modulo depth; count is $clog2(depth)+1 bits.
- The round-robin pick is a function in the arbiter body.

## Test plan
- Hold calib low while port 0 requests a read at 0x100 → no dram_ren. Raise calib → port_ready[0] pulses, then dram_ren with dram_addr=0x100.
- Ports 0 and 1 request reads continuously, dram_busy=0 → grants alternate 0,1,0,1 at one command per cycle. Return 4 beats with data A,B,C,D → port_rvalid sequence 01,10,01,10 with matching data.
- MAX_RD_OUTSTANDING=4, no beats returned, port 0 reads and port 1 writes → after 4 reads only writes issue. One beat returns → one more read issues.
- Hold dram_busy high for 5 cycles during a write with wmask=0x00FF → dram_wen, addr, wdata and wmask stay stable all 5 cycles. Accepted on the first busy-low cycle.
- dram_rdata_valid pulses with no reads outstanding → rd_err=1, port_rvalid stays 0. rd_err stays set until resetn is asserted.
- Assert resetn low asynchronously while dram_ren is held and 2 tags are pending → all outputs return to reset values immediately. The next read goes to port 0.
